// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Constants and receiver state encoding shared by the UART blocks.
// Rev     : 1.0
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 10416;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module  : uart_sync2
// Purpose : Two-flop synchronizer for an asynchronous single-bit input.
// Rev     : 1.0
// ============================================================================
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Purpose : 8N1 UART receiver; define UART_RX_PARITY_EN for an even-parity bit.
// Rev     : 1.0
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int                CNT_W       = $clog2(CLKS_PER_BIT);
    localparam int                IDX_W       = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  C_IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rxd_s;
    uart_rx_state_t       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 perr_q, perr_d;
`endif

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rxd_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxd_s) state_d = ST_START;
            end
            ST_START: begin
                // Mid-bit re-check rejects short low glitches
                if (cnt_q == C_HALF_LAST) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == C_IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = par_bad_q | (^{shift_q, rxd_s});
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = par_bad_q;
`endif
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                cnt_d = '0;
                if (rxd_s) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire
